ysyx_23060240_ifu_prefetch: RTL and testbench

Parametrised instruction-fetch unit with an AXI4 read master and a prefetch FIFO. It issues line-aligned INCR bursts, buffers returned instructions with their PCs, and hands them to the decode stage over a valid/ready handshake. A redirect (jump/branch/trap) flushes the buffer and discards in-flight beats. It sits between the core's PC/redirect logic and the instruction-side AXI interconnect.

---
 rtl/ysyx_23060240_ifu_prefetch.sv | 208 ++++++++++++++++++++
 tb/tb_ysyx_23060240_ifu_prefetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060240_ifu_prefetch.sv
// Instruction fetch unit: AXI4 INCR line-burst read master feeding a {pc, inst, err} prefetch FIFO.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ysyx_23060240_ifu_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          BURST_LEN  = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    output logic        out_err_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [3:0]  arid_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic [3:0]  rid_i,
    output logic [31:0] perf_bursts_o,
    output logic [31:0] perf_drop_beats_o,
    output logic [31:0] perf_empty_cycles_o
);
    localparam int                LINE_B     = BURST_LEN * 4;
    localparam int                BI_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int                PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]       LINE_B32   = 32'(LINE_B);
    localparam logic [31:0]       LINE_MASK  = ~(LINE_B32 - 32'd1);
    localparam logic [31:0]       RESET_LINE = RESET_PC & LINE_MASK;
    localparam logic [BI_W-1:0]   RESET_OFF  = BI_W'((RESET_PC & ~LINE_MASK) >> 2);
    localparam logic [CNT_W-1:0]  ISSUE_MAX  = CNT_W'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_DRAIN, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [31:0]       line_q, line_d, araddr_q;
    logic [BI_W-1:0]   start_off_q, start_off_d, beat_idx_q, beat_idx_d;
    logic              err_seen_q, err_seen_d, ar_flush_q, ar_flush_d;
    logic              arvalid_q, rready_q;

    logic [31:0]       pc_mem   [2**PTR_W];
    logic [31:0]       inst_mem [2**PTR_W];
    logic              err_mem  [2**PTR_W];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic beat, push, pop, drop;
    logic unused_rid;

    assign unused_rid = ^rid_i;

    assign beat = rvalid_i && rready_q;
    // Beats ahead of the redirect target, after an error, or in the redirect cycle never enter the FIFO.
    assign push = (state_q == S_RD) && beat && !redirect_valid_i && !err_seen_q
                  && (beat_idx_q >= start_off_q);
    assign pop  = out_valid_o && out_ready_i;
    assign drop = beat && !push;

    assign out_valid_o = (cnt_q != '0);
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_q]   : 32'd0;
    assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr_q] : 32'd0;
    assign out_err_o   = out_valid_o && err_mem[rd_ptr_q];

    assign araddr_o  = araddr_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'(BURST_LEN - 1);
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        start_off_d = start_off_q;
        beat_idx_d  = beat ? beat_idx_q + BI_W'(1) : beat_idx_q;
        err_seen_d  = err_seen_q;
        ar_flush_d  = ar_flush_q;
        case (state_q)
            S_IDLE: if (cnt_q <= ISSUE_MAX) state_d = S_AR;
            S_AR: begin
                if (arready_i) begin
                    state_d    = (ar_flush_q || redirect_valid_i) ? S_DRAIN : S_RD;
                    ar_flush_d = 1'b0;
                    err_seen_d = 1'b0;
                    beat_idx_d = '0;
                end else if (redirect_valid_i) begin
                    ar_flush_d = 1'b1;
                end
            end
            S_RD: begin
                if (beat) begin
                    if (rresp_i != 2'b00) err_seen_d = 1'b1;
                    if (rlast_i) begin
                        line_d      = line_q + LINE_B32;
                        start_off_d = '0;
                        beat_idx_d  = '0;
                        state_d     = (err_seen_q || rresp_i != 2'b00) ? S_HALT : S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (beat && rlast_i) begin
                    state_d    = S_IDLE;
                    beat_idx_d = '0;
                end
            end
            default: ;
        endcase
        // A redirect retargets the line immediately; an address already on AR must still be drained.
        if (redirect_valid_i) begin
            line_d      = redirect_pc_i & LINE_MASK;
            start_off_d = BI_W'((redirect_pc_i & ~LINE_MASK) >> 2);
            if (state_q == S_IDLE || state_q == S_HALT) begin
                state_d = S_IDLE;
            end else if (state_q == S_RD) begin
                state_d = (beat && rlast_i) ? S_IDLE : S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            line_q      <= RESET_LINE;
            start_off_q <= RESET_OFF;
            beat_idx_q  <= '0;
            err_seen_q  <= 1'b0;
            ar_flush_q  <= 1'b0;
            araddr_q    <= RESET_LINE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            start_off_q <= start_off_d;
            beat_idx_q  <= beat_idx_d;
            err_seen_q  <= err_seen_d;
            ar_flush_q  <= ar_flush_d;
            arvalid_q   <= (state_d == S_AR);
            rready_q    <= (state_d == S_RD) || (state_d == S_DRAIN);
            if (state_d == S_AR && state_q != S_AR) araddr_q <= line_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (redirect_valid_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= line_q + {{(30-BI_W){1'b0}}, beat_idx_q, 2'b00};
            inst_mem[wr_ptr_q] <= rdata_i;
            err_mem[wr_ptr_q]  <= (rresp_i != 2'b00);
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] bursts_q, drops_q, empty_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts_q <= 32'd0;
            drops_q  <= 32'd0;
            empty_q  <= 32'd0;
        end else begin
            if (arvalid_q && arready_i)         bursts_q <= bursts_q + 32'd1;
            if (drop)                           drops_q  <= drops_q + 32'd1;
            if (!out_valid_o && out_ready_i)    empty_q  <= empty_q + 32'd1;
        end
    end

    assign perf_bursts_o       = bursts_q;
    assign perf_drop_beats_o   = drops_q;
    assign perf_empty_cycles_o = empty_q;
`else
    logic unused_drop;
    assign unused_drop         = drop;
    assign perf_bursts_o       = 32'd0;
    assign perf_drop_beats_o   = 32'd0;
    assign perf_empty_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060240_ifu_prefetch.sv
// Directed bench for the prefetching IFU: fetch order, FIFO full stall, redirects, error halt, reset.
module tb_ysyx_23060240_ifu_prefetch;
    logic        clk;
    logic        rst_ni;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        out_err_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [3:0]  arid_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic [3:0]  rid_i;
    logic [31:0] perf_bursts_o;
    logic [31:0] perf_drop_beats_o;
    logic [31:0] perf_empty_cycles_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IFU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    ysyx_23060240_ifu_prefetch dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_pc_o            (out_pc_o),
        .out_inst_o          (out_inst_o),
        .out_err_o           (out_err_o),
        .araddr_o            (araddr_o),
        .arvalid_o           (arvalid_o),
        .arready_i           (arready_i),
        .arid_o              (arid_o),
        .arlen_o             (arlen_o),
        .arsize_o            (arsize_o),
        .arburst_o           (arburst_o),
        .rvalid_i            (rvalid_i),
        .rready_o            (rready_o),
        .rdata_i             (rdata_i),
        .rresp_i             (rresp_i),
        .rlast_i             (rlast_i),
        .rid_i               (rid_i),
        .perf_bursts_o       (perf_bursts_o),
        .perf_drop_beats_o   (perf_drop_beats_o),
        .perf_empty_cycles_o (perf_empty_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ar(input logic [31:0] exp_addr, input string tag);
        int n;
        n = 0;
        while (!arvalid_o && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_arvalid"}, 32'(arvalid_o), 32'd1);
        check_eq({tag, "_araddr"}, araddr_o, exp_addr);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check_eq({tag, "_rready"}, 32'(rready_o), 32'd1);
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
        rvalid_i = 1'b1;
        rdata_i  = data;
        rresp_i  = resp;
        rlast_i  = last;
        tick();
        rvalid_i = 1'b0;
        rresp_i  = 2'b00;
        rlast_i  = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic idle_watch(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            tick();
            seen = seen | arvalid_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_ni = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0; out_ready_i = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0; rresp_i = 2'b00; rlast_i = 1'b0;
        rid_i = 4'h0;
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_arvalid", 32'(arvalid_o), 32'd0);
        check_eq("rst_rready", 32'(rready_o), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_out_err", 32'(out_err_o), 32'd0);
        check_eq("rst_out_pc", out_pc_o, 32'd0);
        check_eq("rst_out_inst", out_inst_o, 32'd0);
        check_eq("rst_araddr", araddr_o, 32'h8000_0000);
        check_eq("rst_perf_bursts", perf_bursts_o, 32'd0);
        check_eq("rst_perf_drops", perf_drop_beats_o, 32'd0);
        check_eq("rst_perf_empty", perf_empty_cycles_o, 32'd0);
        tick(); tick();
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        tick();

        // First line: AR right after reset release, four beats in order.
        check_eq("t1_arvalid_first_edge", 32'(arvalid_o), 32'd1);
        check_eq("t1_arlen", 32'(arlen_o), 32'd3);
        check_eq("t1_arsize", 32'(arsize_o), 32'd2);
        check_eq("t1_arburst", 32'(arburst_o), 32'd1);
        check_eq("t1_arid", 32'(arid_o), 32'd0);
        wait_ar(32'h8000_0000, "t1");
        check_eq("t1_arvalid_drop", 32'(arvalid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'(32'h0000_1000 + i), 2'b00, i == 3);
            check_eq("t1_out_valid", 32'(out_valid_o), 32'd1);
            check_eq("t1_out_pc", out_pc_o, 32'(32'h8000_0000 + 4 * i));
            check_eq("t1_out_inst", out_inst_o, 32'(32'h0000_1000 + i));
        end
        tick();
        check_eq("t1_drained", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b0;

        // Fill: two bursts fill the FIFO, third AR only after four pops.
        wait_ar(32'h8000_0010, "t2a");
        for (int i = 0; i < 4; i++) send_beat(32'(32'h0000_2000 + i), 2'b00, i == 3);
        wait_ar(32'h8000_0020, "t2b");
        for (int i = 0; i < 4; i++) send_beat(32'(32'h0000_2100 + i), 2'b00, i == 3);
        idle_watch(10, seen);
        check_eq("t2_no_ar_full", 32'(seen), 32'd0);
        check_eq("t2_perf_bursts", perf_bursts_o, PERF ? 32'd3 : 32'd0);
        check_eq("t2_head_inst", out_inst_o, 32'h0000_2000);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_pop_pc", out_pc_o, 32'(32'h8000_0010 + 4 * i));
            pop_one();
        end
        idle_watch(5, seen);
        check_eq("t2_no_ar_5", 32'(seen), 32'd0);
        check_eq("t2_pop4_pc", out_pc_o, 32'h8000_001C);
        pop_one();
        wait_ar(32'h8000_0030, "t2c");

        // Redirect after beat 1: beats 2,3 drained, refetch line 0x100 from offset 2.
        send_beat(32'h0000_3000, 2'b00, 1'b0);
        send_beat(32'h0000_3001, 2'b00, 1'b0);
        check_eq("t3_head_before", out_pc_o, 32'h8000_0020);
        redirect(32'h8000_0108);
        check_eq("t3_flush_valid", 32'(out_valid_o), 32'd0);
        check_eq("t3_drain_rready", 32'(rready_o), 32'd1);
        send_beat(32'h0000_3002, 2'b00, 1'b0);
        send_beat(32'h0000_3003, 2'b00, 1'b1);
        check_eq("t3_drained_valid", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b1;
        wait_ar(32'h8000_0100, "t3");
        send_beat(32'h0000_4000, 2'b00, 1'b0);
        check_eq("t3_skip0", 32'(out_valid_o), 32'd0);
        send_beat(32'h0000_4001, 2'b00, 1'b0);
        check_eq("t3_skip1", 32'(out_valid_o), 32'd0);
        send_beat(32'h0000_4002, 2'b00, 1'b0);
        check_eq("t3_first_pc", out_pc_o, 32'h8000_0108);
        check_eq("t3_first_inst", out_inst_o, 32'h0000_4002);
        send_beat(32'h0000_4003, 2'b00, 1'b1);
        check_eq("t3_second_pc", out_pc_o, 32'h8000_010C);
        check_eq("t3_perf_drops", perf_drop_beats_o, PERF ? 32'd4 : 32'd0);
        check_eq("t3_perf_bursts", perf_bursts_o, PERF ? 32'd5 : 32'd0);

        // Redirect while AR is stalled: address held, burst drained, then new line.
        begin
            int n;
            n = 0;
            while (!arvalid_o && n < 40) begin tick(); n++; end
        end
        check_eq("t4_ar_pending", 32'(arvalid_o), 32'd1);
        check_eq("t4_araddr_pre", araddr_o, 32'h8000_0110);
        redirect(32'h8000_0204);
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_arvalid_held", 32'(arvalid_o), 32'd1);
            check_eq("t4_araddr_held", araddr_o, 32'h8000_0110);
            if (i < 2) tick();
        end
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check_eq("t4_drain_rready", 32'(rready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'(32'h0000_6000 + i), 2'b00, i == 3);
            check_eq("t4_drain_valid", 32'(out_valid_o), 32'd0);
        end
        wait_ar(32'h8000_0200, "t4");
        send_beat(32'h0000_6100, 2'b00, 1'b0);
        check_eq("t4_skip0", 32'(out_valid_o), 32'd0);
        for (int i = 1; i < 4; i++) begin
            send_beat(32'(32'h0000_6100 + i), 2'b00, i == 3);
            check_eq("t4_pc", out_pc_o, 32'(32'h8000_0200 + 4 * i));
        end
        check_eq("t4_perf_drops", perf_drop_beats_o, PERF ? 32'd9 : 32'd0);
        check_eq("t4_perf_bursts", perf_bursts_o, PERF ? 32'd7 : 32'd0);

        // Error on beat 2: flagged entry, rest discarded, fetch halts until redirect.
        wait_ar(32'h8000_0210, "t5");
        send_beat(32'h0000_5000, 2'b00, 1'b0);
        check_eq("t5_ok_err", 32'(out_err_o), 32'd0);
        send_beat(32'h0000_5001, 2'b00, 1'b0);
        send_beat(32'h0000_5002, 2'b10, 1'b0);
        check_eq("t5_err_valid", 32'(out_valid_o), 32'd1);
        check_eq("t5_err_pc", out_pc_o, 32'h8000_0218);
        check_eq("t5_err_inst", out_inst_o, 32'h0000_5002);
        check_eq("t5_err_flag", 32'(out_err_o), 32'd1);
        send_beat(32'h0000_5003, 2'b00, 1'b1);
        check_eq("t5_discard", 32'(out_valid_o), 32'd0);
        idle_watch(10, seen);
        check_eq("t5_halt_no_ar", 32'(seen), 32'd0);
        redirect(32'h8000_0300);
        wait_ar(32'h8000_0300, "t5r");
        send_beat(32'h0000_7000, 2'b00, 1'b0);
        check_eq("t5r_pc", out_pc_o, 32'h8000_0300);
        check_eq("t5r_err", 32'(out_err_o), 32'd0);
        send_beat(32'h0000_7001, 2'b00, 1'b0);

        // Reset mid-burst: outputs return to reset values at once, fetch restarts at RESET_PC.
        rst_ni = 1'b0;
        #1;
        check_eq("t6_arvalid", 32'(arvalid_o), 32'd0);
        check_eq("t6_rready", 32'(rready_o), 32'd0);
        check_eq("t6_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("t6_out_pc", out_pc_o, 32'd0);
        check_eq("t6_araddr", araddr_o, 32'h8000_0000);
        check_eq("t6_perf_bursts", perf_bursts_o, 32'd0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        check_eq("t6_restart_arvalid", 32'(arvalid_o), 32'd1);
        check_eq("t6_restart_araddr", araddr_o, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
